// File: rtl/ql_bank_pkg.sv
// ql_bank_pkg: shared state type and phase-counter sizing for the bank programmer
package ql_bank_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} ql_bank_state_t;

    function automatic int ql_bank_phase_w(input int s, input int p, input int h);
        int m;
        m = (s > p) ? s : p;
        m = (m > h) ? m : h;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ql_wl_decoder.sv
// ql_wl_decoder: binary word-line index to one-hot select, all-zero when disabled
module ql_wl_decoder #(
    parameter int WIDTH = 204,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [0:WIDTH-1] dec
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign dec[i] = en & (addr == AW'(i));
    end

endmodule

// File: rtl/ql_bank_programmer.sv
// ql_bank_programmer: writes one configuration row per frame with setup / wl pulse / hold timing
module ql_bank_programmer
    import ql_bank_pkg::*;
#(
    parameter int BL_WIDTH  = 204,
    parameter int WL_WIDTH  = 204,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    localparam int WL_AW    = $clog2(WL_WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frm_valid,
    output logic                frm_ready,
    input  logic [WL_AW-1:0]    frm_wl_addr,
    input  logic [BL_WIDTH-1:0] frm_bl_data,
    input  logic                err_clr,
    output logic [0:BL_WIDTH-1] bl,
    output logic [0:WL_WIDTH-1] wl,
    output logic                busy,
    output logic                err_addr,
    output logic [15:0]         frames_done
);

    localparam int PW = ql_bank_phase_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    ql_bank_state_t      state, state_n;
    logic [PW-1:0]       cnt, cnt_n;
    logic [WL_AW-1:0]    addr_q;
    logic [0:WL_WIDTH-1] wl_n;
    logic                take, addr_ok, good, bad, done;

    assign frm_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign take      = frm_valid & frm_ready;
    assign addr_ok   = int'(frm_wl_addr) < WL_WIDTH;
    assign good      = take & addr_ok;
    assign bad       = take & ~addr_ok;

    // Phase sequencing: each phase reloads the shared down-counter on entry and leaves when it hits zero
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (good) begin
                    state_n = SETUP;
                    cnt_n   = PW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                state_n = (cnt == '0) ? PULSE : SETUP;
                cnt_n   = (cnt == '0) ? PW'(PULSE_CYC - 1) : cnt - PW'(1);
            end
            PULSE: begin
                state_n = (cnt == '0) ? HOLD : PULSE;
                cnt_n   = (cnt == '0) ? PW'(HOLD_CYC - 1) : cnt - PW'(1);
            end
            default: begin
                state_n = (cnt == '0) ? IDLE : HOLD;
                cnt_n   = (cnt == '0) ? '0 : cnt - PW'(1);
                done    = (cnt == '0);
            end
        endcase
    end

    ql_wl_decoder #(.WIDTH(WL_WIDTH), .AW(WL_AW)) u_dec (
        .en   (state_n == PULSE),
        .addr (addr_q),
        .dec  (wl_n)
    );

    // Registered state, latches and line drivers; reset drops bl/wl at once and abandons the frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            bl          <= '0;
            wl          <= '0;
            err_addr    <= 1'b0;
            frames_done <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            addr_q      <= good ? frm_wl_addr : addr_q;
            bl          <= good ? frm_bl_data : (done ? '0 : bl);
            wl          <= wl_n;
            err_addr    <= bad ? 1'b1 : (err_clr ? 1'b0 : err_addr);
            frames_done <= (done && frames_done != 16'hFFFF) ? frames_done + 16'd1 : frames_done;
        end
    end

endmodule

// File: doc/ql_bank_programmer.md
# ql_bank_programmer

Drives the bit-line (`bl`) and word-line (`wl`) buses of a QuickLogic-style memory-bank configuration array, such as the bank feeding a `k4_N4` CLB tile. It accepts one configuration frame per handshake: a word-line index and a full bit-line data word. For each frame it runs a registered setup → word-line pulse → hold sequence, so a single configuration row is written with clean, non-overlapping timing. It sits between the bitstream loader and the fabric's `bl`/`wl` inputs.

## Interface
Parameters:
- `BL_WIDTH`, default 204: number of bit-lines (columns) driven in parallel.
- `WL_WIDTH`, default 204: number of word-lines (rows); address width `WL_AW = $clog2(WL_WIDTH)`.
- `SETUP_CYC`, default 1: cycles `bl` is stable before `wl` rises (≥1).
- `PULSE_CYC`, default 2: cycles the selected `wl` is high (≥1).
- `HOLD_CYC`, default 1: cycles `bl` is held after `wl` falls (≥1).

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frm_valid`  in  1  frame offered.
- `frm_ready`  out  1  block can accept a frame.
- `frm_wl_addr`  in  WL_AW  target word-line index.
- `frm_bl_data`  in  BL_WIDTH  data for all bit-lines.
- `err_clr`  in  1  clears `err_addr`.
- `bl`  out  [0:BL_WIDTH-1]  bit-line drive.
- `wl`  out  [0:WL_WIDTH-1]  word-line drive, one-hot or zero.
- `busy`  out  1  a sequence is in progress.
- `err_addr`  out  1  sticky flag: an out-of-range address was received.
- `frames_done`  out  16  count of completed valid frames, saturating at 16'hFFFF.

## Operation
- States: `IDLE`, `SETUP`, `PULSE`, `HOLD`.
- `frm_ready` = 1 only in `IDLE`. A transfer occurs when `frm_valid & frm_ready` at a rising edge.
- On a transfer with `frm_wl_addr < WL_WIDTH`:
  - latch address and data;
  - `bl` ← data;
  - go to `SETUP`.
- On a transfer with `frm_wl_addr >= WL_WIDTH`:
  - set `err_addr`;
  - stay in `IDLE`;
  - `bl`/`wl` are unchanged (zero);
  - the frame is consumed and not counted.
- `SETUP`: `wl` = 0; stay for `SETUP_CYC` cycles, then go to `PULSE`.
- `PULSE`: `wl[addr]` = 1, all other `wl` bits = 0; stay for `PULSE_CYC` cycles, then go to `HOLD`.
- `HOLD`: `wl` = 0, `bl` held; stay for `HOLD_CYC` cycles. Then `bl` ← 0, `frames_done` += 1 (saturating), go to `IDLE`.
- A single down-counter of width `$clog2(max(SETUP,PULSE,HOLD)+1)` times each phase. It is reloaded on every state entry.
- `busy` = (state != `IDLE`).
- `err_clr` clears `err_addr`. If `err_clr` and a new bad address occur in the same cycle, the set wins.
- `bl` and `wl` are registered outputs and never glitch. At most one `wl` bit is high at any time.

## Timing
- All outputs reset to 0 except `frm_ready`, which resets to 1.
- Reset asserted mid-sequence forces `wl` and `bl` to 0 immediately (asynchronously). State returns to `IDLE` and the interrupted frame is not counted.
- With transfer at edge T:
  - `bl` valid from T+1;
  - `wl` high for edges T+1+S … T+S+P;
  - `bl` returns to 0 and `frm_ready` rises at T+1+S+P+H.
- Defaults: `wl` is high in cycles T+2 and T+3, and `frm_ready` returns at T+5.
- Back-to-back frames are separated by exactly one `IDLE` cycle. There is no `wl` overlap between frames.
- A bad-address transfer leaves `frm_ready` = 1 and shows `err_addr` = 1 from T+1.

## Structure
- Package `ql_bank_pkg`: state enum `ql_bank_state_t` and a `ql_bank_phase_w` function computing the counter width.
- Sub-module `ql_wl_decoder`: combinational binary-to-one-hot decoder with an enable; output is all-zero when disabled. The parent registers its output.
- The parent holds the FSM, phase counter, data/address latches, error flag and frame counter.

## Test plan
- Reset, then addr=5 with data=all-ones (defaults):
  - `bl` is all-ones at T+1;
  - only `wl[5]` is high at T+2 and T+3;
  - `bl`=0 and `frames_done`=1 at T+5.
- Two frames presented back-to-back (addr 0, then addr 203):
  - second transfer accepted at T+5;
  - `wl[0]` and `wl[203]` are never high in the same cycle.
- addr=204:
  - `err_addr`=1, no `wl` activity, `frames_done` unchanged;
  - `err_clr` returns `err_addr` to 0.
- `reset` pulsed low during `PULSE`:
  - `wl`/`bl` are 0 in the same cycle;
  - `frm_ready`=1 after release;
  - `frames_done`=0.
- Parameters S=3, P=5, H=2:
  - `wl` high for exactly 5 cycles starting at T+4;
  - `frm_ready` returns at T+11.
- `frm_valid` held high while busy:
  - no new transfer occurs until `frm_ready`=1;
  - the latched address/data are not overwritten mid-sequence.
